// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: a pixel-tick divider drives h/v scan counters, and
// one registered output stage turns the pixel source's colour into DAC/sync signals.
module vga_scan_driver #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        color,
  output logic signed [15:0] pix_x,
  output logic signed [15:0] pix_y,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW       = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0]   H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0]   V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0]   H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0]   V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0]   HS_BEGIN = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0]   HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0]   VS_BEGIN = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0]   VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_div;
  logic [15:0]   r_h;
  logic [15:0]   r_v;
  logic [11:0]   r_rgb;
  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_start;

  logic w_tick;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hsync;
  logic w_vsync;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hsync  = !((r_h >= HS_BEGIN) && (r_h < HS_END));
  assign w_vsync  = !((r_v >= VS_BEGIN) && (r_v < VS_END));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // v only moves on the tick that wraps h, so both land on 0 at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 16'd1;
      end else begin
        r_h <= r_h + 16'd1;
      end
    end
  end

  // Output stage samples the counters from before the tick, giving one pixel of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb   <= '0;
      r_de    <= 1'b0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_rgb   <= w_active ? color : 12'h000;
      r_de    <= w_active;
      r_hsync <= w_hsync;
      r_vsync <= w_vsync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
    end
  end

  assign pix_x       = $signed(r_h);
  assign pix_y       = $signed(r_v);
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: a default-timing instance for the first line, and a shrunken-timing
// instance (25x13 pixels) for frame-level, blanking, lookup and mid-frame reset checks.
module tb_vga_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- default-parameter instance ----------------
  logic               rst_d = 1'b0;
  logic [11:0]        color_d = 12'hF0A;
  logic signed [15:0] pix_x_d, pix_y_d;
  logic [3:0]         r_d, g_d, b_d;
  logic               hs_d, vs_d, de_d, fs_d;

  vga_scan_driver dut_d (
    .clk(clk), .reset(rst_d), .color(color_d),
    .pix_x(pix_x_d), .pix_y(pix_y_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .frame_start(fs_d)
  );

  // ---------------- small-timing instance ----------------
  // H: 16 active, 2 fp, 4 sync (h 18..21), 3 bp -> 25.  V: 8 active, 1 fp, 2 sync (v 9..10), 2 bp -> 13.
  logic               rst_s = 1'b0;
  logic [11:0]        color_vec = 12'h000;
  logic [11:0]        lut_q = 12'h000;
  logic               use_lut = 1'b0;
  logic [11:0]        color_s;
  logic signed [15:0] pix_x_s, pix_y_s;
  logic [3:0]         r_s, g_s, b_s;
  logic               hs_s, vs_s, de_s, fs_s;

  always @(posedge clk) lut_q <= pix_x_s[11:0];
  assign color_s = use_lut ? lut_q : color_vec;

  vga_scan_driver #(
    .CLK_DIV(4),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk(clk), .reset(rst_s), .color(color_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .frame_start(fs_s)
  );

  typedef struct {
    int          h;
    int          v;
    logic [11:0] color;
    logic        de;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  // Stops on the first negedge where the small instance shows (h,v).
  task automatic wait_pix(input int h, input int v);
    int k;
    k = 0;
    while (!(int'(pix_x_s) == h && int'(pix_y_s) == v) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk($sformatf("wait_pix_%0d_%0d_timeout", h, v), 32'd0, 32'd1);
  endtask

  // Stops on the negedge just after the next pixel tick of the small instance.
  task automatic wait_tick_s();
    logic signed [15:0] x0, y0;
    int k;
    x0 = pix_x_s;
    y0 = pix_y_s;
    k = 0;
    while (pix_x_s == x0 && pix_y_s == y0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, first_hs_x, cnt;
    logic signed [15:0] px_prev;

    vecs[0]  = '{0,  0,  12'hF0A, 1'b1, 4'hF, 4'h0, 4'hA, 1'b1, 1'b1};
    vecs[1]  = '{5,  0,  12'h123, 1'b1, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1};
    vecs[2]  = '{15, 0,  12'hABC, 1'b1, 4'hA, 4'hB, 4'hC, 1'b1, 1'b1};
    vecs[3]  = '{16, 0,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[4]  = '{17, 0,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[5]  = '{18, 0,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[6]  = '{21, 0,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[7]  = '{22, 0,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[8]  = '{24, 0,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[9]  = '{0,  1,  12'h5A5, 1'b1, 4'h5, 4'hA, 4'h5, 1'b1, 1'b1};
    vecs[10] = '{15, 7,  12'h777, 1'b1, 4'h7, 4'h7, 4'h7, 1'b1, 1'b1};
    vecs[11] = '{0,  8,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[12] = '{3,  9,  12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[13] = '{20, 10, 12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[14] = '{0,  11, 12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[15] = '{24, 12, 12'hFFF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};

    // ---- default instance: reset state, first tick, one full line ----
    repeat (3) @(negedge clk);
    chk("rst_d_pix_x", 32'(pix_x_d), 32'd0);
    chk("rst_d_pix_y", 32'(pix_y_d), 32'd0);
    chk("rst_d_rgb",   {20'd0, r_d, g_d, b_d}, 32'd0);
    chk("rst_d_de",    32'(de_d), 32'd0);
    chk("rst_d_hs",    32'(hs_d), 32'd1);
    chk("rst_d_vs",    32'(vs_d), 32'd1);
    chk("rst_d_fs",    32'(fs_d), 32'd0);
    rst_d = 1'b1;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; first_hs_x = -1;
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("d_k3_pix_x", 32'(pix_x_d), 32'd0);
        chk("d_k3_de",    32'(de_d), 32'd0);
      end
      if (k == 4) begin
        chk("d_first_tick_pix_x", 32'(pix_x_d), 32'd1);
        chk("d_first_tick_de",    32'(de_d), 32'd1);
        chk("d_first_tick_rgb",   {20'd0, r_d, g_d, b_d}, 32'hF0A);
      end
      if (de_d) de_cnt++;
      if (!hs_d) begin
        hs_cnt++;
        if (first_hs_x < 0) first_hs_x = int'(pix_x_d);
      end
      if (!vs_d) vs_cnt++;
      if (fs_d) fs_cnt++;
    end
    chk("d_line_de_clks",      32'(de_cnt), 32'd2560);
    chk("d_line_hsync_clks",   32'(hs_cnt), 32'd384);
    chk("d_first_hsync_pix_x", 32'(first_hs_x), 32'd657);
    chk("d_line_vsync_clks",   32'(vs_cnt), 32'd0);
    chk("d_line_fs_pulses",    32'(fs_cnt), 32'd0);
    chk("d_line_end_pix_x",    32'(pix_x_d), 32'd0);
    chk("d_line_end_pix_y",    32'(pix_y_d), 32'd1);

    // ---- small instance: table of scan positions over the first frame ----
    @(negedge clk);
    chk("rst_s_hs", 32'(hs_s), 32'd1);
    chk("rst_s_fs", 32'(fs_s), 32'd0);
    rst_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_pix(vecs[i].h, vecs[i].v);
      color_vec = vecs[i].color;
      wait_tick_s();
      chk($sformatf("vec%0d_de", i),  32'(de_s), 32'(vecs[i].de));
      chk($sformatf("vec%0d_rgb", i), {20'd0, r_s, g_s, b_s},
          {20'd0, vecs[i].r, vecs[i].g, vecs[i].b});
      chk($sformatf("vec%0d_hs", i),  32'(hs_s), 32'(vecs[i].hs));
      chk($sformatf("vec%0d_vs", i),  32'(vs_s), 32'(vecs[i].vs));
    end

    // Last vector's tick wraps both counters: frame_start fires right here.
    chk("fs_at_wrap",       32'(fs_s), 32'd1);
    chk("fs_at_wrap_pix_x", 32'(pix_x_s), 32'd0);
    chk("fs_at_wrap_pix_y", 32'(pix_y_s), 32'd0);
    @(negedge clk);
    chk("fs_width_one_clk", 32'(fs_s), 32'd0);
    cnt = 1;
    while (!fs_s && cnt < 1400) begin
      @(negedge clk);
      cnt++;
    end
    chk("fs_period_clks", 32'(cnt), 32'd1300);
    chk("fs_pix_x", 32'(pix_x_s), 32'd0);
    chk("fs_pix_y", 32'(pix_y_s), 32'd0);

    // ---- registered lookup source: colour = previous pix_x ----
    use_lut = 1'b1;
    for (int i = 0; i < 16; i++) begin
      px_prev = pix_x_s;
      wait_tick_s();
      chk($sformatf("lut_h%0d_b", i), 32'(b_s), 32'(px_prev[3:0]));
    end
    use_lut = 1'b0;

    // ---- reset pulsed mid-frame ----
    wait_pix(10, 5);
    color_vec = 12'h5A5;
    wait_tick_s();
    chk("mid_pre_de", 32'(de_s), 32'd1);
    #1 rst_s = 1'b0;
    #1;
    chk("mid_rst_pix_x", 32'(pix_x_s), 32'd0);
    chk("mid_rst_pix_y", 32'(pix_y_s), 32'd0);
    chk("mid_rst_rgb",   {20'd0, r_s, g_s, b_s}, 32'd0);
    chk("mid_rst_de",    32'(de_s), 32'd0);
    chk("mid_rst_hs_vs", {30'd0, hs_s, vs_s}, 32'd3);
    chk("mid_rst_fs",    32'(fs_s), 32'd0);
    repeat (3) @(negedge clk);
    rst_s = 1'b1;
    fs_cnt = 0;
    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (k == 3) chk("restart_k3_pix_x", 32'(pix_x_s), 32'd0);
      if (k == 4) begin
        chk("restart_k4_pix_x", 32'(pix_x_s), 32'd1);
        chk("restart_k4_pix_y", 32'(pix_y_s), 32'd0);
      end
      if (k < 1300 && fs_s) fs_cnt++;
      if (k == 1300) chk("restart_first_fs", 32'(fs_s), 32'd1);
    end
    chk("restart_no_early_fs", 32'(fs_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
